// File: rtl/RV32I_definitions.sv
// Shared RV32I pipeline definitions.
// Holds the memory port arbiter state encoding and bus constants.
package RV32I_definitions;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_WAIT  = 2'd1,
        MEM_WAIT = 2'd2,
        IF_DROP  = 2'd3
    } arb_state_t;

    localparam int BUS_BE_MAX = 64;

    // Sliced down to the real byte-enable width by each user.
    localparam logic [BUS_BE_MAX-1:0] BUS_BE_ALL = '1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter sharing one bus between IF and MEM.
// One outstanding transaction; MEM has fixed priority over fetch.
module mem_port_arbiter
    import RV32I_definitions::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    IF_Req,
    input  logic [ADDR_WIDTH-1:0]   IF_Addr,
    output logic [DATA_WIDTH-1:0]   IF_Rdata,
    output logic                    IF_Ack,
    input  logic                    MEM_Req,
    input  logic                    MEM_We,
    input  logic [ADDR_WIDTH-1:0]   MEM_Addr,
    input  logic [DATA_WIDTH-1:0]   MEM_Wdata,
    input  logic [DATA_WIDTH/8-1:0] MEM_Be,
    output logic [DATA_WIDTH-1:0]   MEM_Rdata,
    output logic                    MEM_Ack,
    input  logic                    Flush,
    output logic                    Bus_Valid,
    output logic                    Bus_We,
    output logic [ADDR_WIDTH-1:0]   Bus_Addr,
    output logic [DATA_WIDTH-1:0]   Bus_Wdata,
    output logic [DATA_WIDTH/8-1:0] Bus_Be,
    input  logic                    Bus_Ready,
    input  logic [DATA_WIDTH-1:0]   Bus_Rdata,
    output logic                    Mem_Stall
);

    localparam int BW = DATA_WIDTH / 8;
    localparam logic [BW-1:0] BE_ALL = BUS_BE_ALL[BW-1:0];

    arb_state_t            state_q, state_d;
    logic                  valid_q, valid_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BW-1:0]         be_q, be_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
    logic                  if_ack_q, if_ack_d;
    logic                  mem_ack_q, mem_ack_d;
    logic                  ack_bubble;

    // No grant in an Ack cycle so the requester can drop its Req first.
    assign ack_bubble = if_ack_q | mem_ack_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ack_bubble) begin
                    if (MEM_Req) begin
                        state_d = MEM_WAIT;
                        valid_d = 1'b1;
                        we_d    = MEM_We;
                        addr_d  = MEM_Addr;
                        wdata_d = MEM_We ? MEM_Wdata : '0;
                        be_d    = MEM_We ? MEM_Be : BE_ALL;
                    end else if (IF_Req && !Flush) begin
                        state_d = IF_WAIT;
                        valid_d = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = IF_Addr;
                        wdata_d = '0;
                        be_d    = BE_ALL;
                    end
                end
            end
            IF_WAIT: begin
                if (Bus_Ready) begin
                    state_d    = IDLE;
                    valid_d    = 1'b0;
                    if_rdata_d = Bus_Rdata;
                    if_ack_d   = !Flush;
                end else if (Flush) begin
                    state_d = IF_DROP;
                end
            end
            MEM_WAIT: begin
                if (Bus_Ready) begin
                    state_d     = IDLE;
                    valid_d     = 1'b0;
                    mem_rdata_d = Bus_Rdata;
                    mem_ack_d   = 1'b1;
                end
            end
            IF_DROP: begin
                if (Bus_Ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
        end
    end

    assign Bus_Valid = valid_q;
    assign Bus_We    = we_q;
    assign Bus_Addr  = addr_q;
    assign Bus_Wdata = wdata_q;
    assign Bus_Be    = be_q;
    assign IF_Rdata  = if_rdata_q;
    assign IF_Ack    = if_ack_q;
    assign MEM_Rdata = mem_rdata_q;
    assign MEM_Ack   = mem_ack_q;

    assign Mem_Stall = (IF_Req & ~if_ack_q & ~Flush)
                     | (MEM_Req & ~mem_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Each task drives one scenario and checks cycle by cycle.
module tb_mem_port_arbiter;

    logic        Clk;
    logic        Reset_n;
    logic        IF_Req;
    logic [31:0] IF_Addr;
    logic [31:0] IF_Rdata;
    logic        IF_Ack;
    logic        MEM_Req;
    logic        MEM_We;
    logic [31:0] MEM_Addr;
    logic [31:0] MEM_Wdata;
    logic [3:0]  MEM_Be;
    logic [31:0] MEM_Rdata;
    logic        MEM_Ack;
    logic        Flush;
    logic        Bus_Valid;
    logic        Bus_We;
    logic [31:0] Bus_Addr;
    logic [31:0] Bus_Wdata;
    logic [3:0]  Bus_Be;
    logic        Bus_Ready;
    logic [31:0] Bus_Rdata;
    logic        Mem_Stall;

    int total = 0;
    int bad = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .IF_Req(IF_Req), .IF_Addr(IF_Addr),
        .IF_Rdata(IF_Rdata), .IF_Ack(IF_Ack),
        .MEM_Req(MEM_Req), .MEM_We(MEM_We),
        .MEM_Addr(MEM_Addr), .MEM_Wdata(MEM_Wdata),
        .MEM_Be(MEM_Be), .MEM_Rdata(MEM_Rdata),
        .MEM_Ack(MEM_Ack), .Flush(Flush),
        .Bus_Valid(Bus_Valid), .Bus_We(Bus_We),
        .Bus_Addr(Bus_Addr), .Bus_Wdata(Bus_Wdata),
        .Bus_Be(Bus_Be), .Bus_Ready(Bus_Ready),
        .Bus_Rdata(Bus_Rdata), .Mem_Stall(Mem_Stall)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        cyc();
        cyc();
        total++;
        if ({Bus_Valid, Bus_We, IF_Ack, MEM_Ack} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0000",
                     {Bus_Valid, Bus_We, IF_Ack, MEM_Ack});
        end
        total++;
        if ({Bus_Addr, Bus_Wdata, Bus_Be} !== 68'h0) begin
            bad++;
            $display("FAIL reset_bus got=%h want=0",
                     {Bus_Addr, Bus_Wdata, Bus_Be});
        end
        total++;
        if ({IF_Rdata, MEM_Rdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset_rdata got=%h want=0",
                     {IF_Rdata, MEM_Rdata});
        end
        Reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_fetch();
        IF_Req = 1'b1;
        IF_Addr = 32'h100;
        Bus_Rdata = 32'h00500093;
        #1;
        total++;
        if (Mem_Stall !== 1'b1) begin
            bad++;
            $display("FAIL fetch_stall_c0 got=%b want=1", Mem_Stall);
        end
        cyc();
        total++;
        if ({Bus_Valid, Bus_We, Bus_Addr, Bus_Be} !== {2'b10, 32'h100, 4'hF}) begin
            bad++;
            $display("FAIL fetch_bus_c1 got=%b%b %h %h want=10 100 f",
                     Bus_Valid, Bus_We, Bus_Addr, Bus_Be);
        end
        total++;
        if ({Mem_Stall, IF_Ack} !== 2'b10) begin
            bad++;
            $display("FAIL fetch_stall_c1 got=%b want=10", {Mem_Stall, IF_Ack});
        end
        Bus_Ready = 1'b1;
        cyc();
        total++;
        if ({IF_Ack, IF_Rdata} !== {1'b1, 32'h00500093}) begin
            bad++;
            $display("FAIL fetch_ack_c2 got=%b %h want=1 00500093",
                     IF_Ack, IF_Rdata);
        end
        total++;
        if ({Bus_Valid, Mem_Stall} !== 2'b00) begin
            bad++;
            $display("FAIL fetch_done_c2 got=%b want=00", {Bus_Valid, Mem_Stall});
        end
        IF_Req = 1'b0;
        Bus_Ready = 1'b0;
        cyc();
        total++;
        if ({IF_Ack, Bus_Valid} !== 2'b00) begin
            bad++;
            $display("FAIL fetch_after got=%b want=00", {IF_Ack, Bus_Valid});
        end
    endtask

    task automatic test_simultaneous();
        IF_Req = 1'b1;
        IF_Addr = 32'h104;
        MEM_Req = 1'b1;
        MEM_We = 1'b1;
        MEM_Addr = 32'h2000;
        MEM_Wdata = 32'hDEADBEEF;
        MEM_Be = 4'h3;
        Bus_Ready = 1'b1;
        cyc();
        total++;
        if ({Bus_Valid, Bus_We, Bus_Addr, Bus_Wdata, Bus_Be} !==
            {2'b11, 32'h2000, 32'hDEADBEEF, 4'h3}) begin
            bad++;
            $display("FAIL simul_store got=%b%b %h %h %h want=11 2000 deadbeef 3",
                     Bus_Valid, Bus_We, Bus_Addr, Bus_Wdata, Bus_Be);
        end
        cyc();
        total++;
        if ({MEM_Ack, IF_Ack, Bus_Valid, Mem_Stall} !== 4'b1001) begin
            bad++;
            $display("FAIL simul_mack got=%b want=1001",
                     {MEM_Ack, IF_Ack, Bus_Valid, Mem_Stall});
        end
        MEM_Req = 1'b0;
        MEM_We = 1'b0;
        Bus_Rdata = 32'h12345678;
        cyc();
        total++;
        if ({Bus_Valid, MEM_Ack} !== 2'b00) begin
            bad++;
            $display("FAIL simul_bubble got=%b want=00", {Bus_Valid, MEM_Ack});
        end
        cyc();
        total++;
        if ({Bus_Valid, Bus_We, Bus_Addr, Bus_Wdata, Bus_Be} !==
            {2'b10, 32'h104, 32'h0, 4'hF}) begin
            bad++;
            $display("FAIL simul_fetch got=%b%b %h %h %h want=10 104 0 f",
                     Bus_Valid, Bus_We, Bus_Addr, Bus_Wdata, Bus_Be);
        end
        cyc();
        total++;
        if ({IF_Ack, IF_Rdata} !== {1'b1, 32'h12345678}) begin
            bad++;
            $display("FAIL simul_iack got=%b %h want=1 12345678",
                     IF_Ack, IF_Rdata);
        end
        IF_Req = 1'b0;
        Bus_Ready = 1'b0;
        cyc();
    endtask

    task automatic test_wait_states();
        MEM_Req = 1'b1;
        MEM_We = 1'b0;
        MEM_Addr = 32'h40;
        MEM_Wdata = 32'h55;
        MEM_Be = 4'h3;
        Bus_Ready = 1'b0;
        cyc();
        total++;
        if ({Bus_We, Bus_Wdata, Bus_Be} !== {1'b0, 32'h0, 4'hF}) begin
            bad++;
            $display("FAIL wait_load_fields got=%b %h %h want=0 0 f",
                     Bus_We, Bus_Wdata, Bus_Be);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            total++;
            if ({Bus_Valid, Bus_Addr, MEM_Ack} !== {1'b1, 32'h40, 1'b0}) begin
                bad++;
                $display("FAIL wait_hold_%0d got=%b %h %b want=1 40 0",
                         i, Bus_Valid, Bus_Addr, MEM_Ack);
            end
        end
        Bus_Ready = 1'b1;
        Bus_Rdata = 32'hCAFEF00D;
        cyc();
        total++;
        if ({MEM_Ack, MEM_Rdata, Bus_Valid} !== {1'b1, 32'hCAFEF00D, 1'b0}) begin
            bad++;
            $display("FAIL wait_ack got=%b %h %b want=1 cafef00d 0",
                     MEM_Ack, MEM_Rdata, Bus_Valid);
        end
        MEM_Req = 1'b0;
        Bus_Ready = 1'b0;
        cyc();
    endtask

    task automatic test_flush_idle();
        IF_Req = 1'b1;
        IF_Addr = 32'h600;
        Flush = 1'b1;
        #1;
        total++;
        if (Mem_Stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_stall got=%b want=0", Mem_Stall);
        end
        cyc();
        total++;
        if (Bus_Valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_grant got=%b want=0", Bus_Valid);
        end
        IF_Req = 1'b0;
        Flush = 1'b0;
        cyc();
    endtask

    task automatic test_flush_inflight();
        IF_Req = 1'b1;
        IF_Addr = 32'h200;
        Bus_Ready = 1'b0;
        cyc();
        Flush = 1'b1;
        IF_Req = 1'b0;
        cyc();
        total++;
        if ({Bus_Valid, Bus_Addr} !== {1'b1, 32'h200}) begin
            bad++;
            $display("FAIL drop_hold1 got=%b %h want=1 200", Bus_Valid, Bus_Addr);
        end
        Flush = 1'b0;
        cyc();
        total++;
        if ({Bus_Valid, IF_Ack} !== 2'b10) begin
            bad++;
            $display("FAIL drop_hold2 got=%b want=10", {Bus_Valid, IF_Ack});
        end
        Bus_Ready = 1'b1;
        Bus_Rdata = 32'hBAD0BAD0;
        cyc();
        total++;
        if ({Bus_Valid, IF_Ack, IF_Rdata} !== {2'b00, 32'h12345678}) begin
            bad++;
            $display("FAIL drop_done got=%b%b %h want=00 12345678",
                     Bus_Valid, IF_Ack, IF_Rdata);
        end
        Bus_Ready = 1'b0;
        IF_Req = 1'b1;
        IF_Addr = 32'h300;
        cyc();
        total++;
        if ({Bus_Valid, Bus_Addr} !== {1'b1, 32'h300}) begin
            bad++;
            $display("FAIL drop_regrant got=%b %h want=1 300", Bus_Valid, Bus_Addr);
        end
        Bus_Ready = 1'b1;
        Bus_Rdata = 32'h00000013;
        cyc();
        total++;
        if ({IF_Ack, IF_Rdata} !== {1'b1, 32'h13}) begin
            bad++;
            $display("FAIL drop_newack got=%b %h want=1 00000013", IF_Ack, IF_Rdata);
        end
        IF_Req = 1'b0;
        Bus_Ready = 1'b0;
        cyc();
    endtask

    task automatic test_flush_ready();
        IF_Req = 1'b1;
        IF_Addr = 32'h400;
        cyc();
        Flush = 1'b1;
        IF_Req = 1'b0;
        Bus_Ready = 1'b1;
        Bus_Rdata = 32'h0BADF00D;
        cyc();
        total++;
        if ({IF_Ack, Bus_Valid, IF_Rdata} !== {2'b00, 32'h0BADF00D}) begin
            bad++;
            $display("FAIL flushrdy got=%b%b %h want=00 0badf00d",
                     IF_Ack, Bus_Valid, IF_Rdata);
        end
        Flush = 1'b0;
        Bus_Ready = 1'b0;
        cyc();
        total++;
        if (IF_Ack !== 1'b0) begin
            bad++;
            $display("FAIL flushrdy_late got=%b want=0", IF_Ack);
        end
    endtask

    task automatic test_reset_midop();
        MEM_Req = 1'b1;
        MEM_We = 1'b1;
        MEM_Addr = 32'h80;
        MEM_Wdata = 32'h11;
        MEM_Be = 4'hF;
        Bus_Ready = 1'b0;
        cyc();
        total++;
        if ({Bus_Valid, Bus_We} !== 2'b11) begin
            bad++;
            $display("FAIL rst_mid_pre got=%b want=11", {Bus_Valid, Bus_We});
        end
        Reset_n = 1'b0;
        MEM_Req = 1'b0;
        MEM_We = 1'b0;
        cyc();
        total++;
        if ({Bus_Valid, Bus_We, IF_Ack, MEM_Ack, Mem_Stall, Bus_Addr,
             Bus_Wdata, Bus_Be, IF_Rdata, MEM_Rdata} !== 137'h0) begin
            bad++;
            $display("FAIL rst_mid got=%b%b %h %h %h %h want=all zero",
                     Bus_Valid, Bus_We, Bus_Addr, Bus_Wdata, Bus_Be, IF_Rdata);
        end
        Reset_n = 1'b1;
        cyc();
        IF_Req = 1'b1;
        IF_Addr = 32'h500;
        cyc();
        total++;
        if ({Bus_Valid, Bus_We, Bus_Addr} !== {2'b10, 32'h500}) begin
            bad++;
            $display("FAIL rst_mid_idle got=%b%b %h want=10 500",
                     Bus_Valid, Bus_We, Bus_Addr);
        end
        Bus_Ready = 1'b1;
        Bus_Rdata = 32'h00A00113;
        cyc();
        total++;
        if ({IF_Ack, IF_Rdata} !== {1'b1, 32'h00A00113}) begin
            bad++;
            $display("FAIL rst_mid_fetch got=%b %h want=1 00a00113",
                     IF_Ack, IF_Rdata);
        end
        IF_Req = 1'b0;
        Bus_Ready = 1'b0;
        cyc();
    endtask

    initial begin
        Reset_n = 1'b0;
        IF_Req = 1'b0;
        IF_Addr = '0;
        MEM_Req = 1'b0;
        MEM_We = 1'b0;
        MEM_Addr = '0;
        MEM_Wdata = '0;
        MEM_Be = '0;
        Flush = 1'b0;
        Bus_Ready = 1'b0;
        Bus_Rdata = '0;
        test_reset();
        test_fetch();
        test_simultaneous();
        test_wait_states();
        test_flush_idle();
        test_flush_inflight();
        test_flush_ready();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter for the RV32I pipeline. It shares one external memory bus between the instruction-fetch (IF) requester and the load/store (MEM) requester. It sequences one outstanding bus transaction at a time through a small FSM and raises a pipeline stall to the hazard/stall logic while either requester waits. The block sits between the IF/MEM stages and the memory bus, alongside the pipeline hazard unit, which ORs `Mem_Stall` into its global stall.

## Interface
- `ADDR_WIDTH`, default 32: byte address width.
- `DATA_WIDTH`, default 32: bus data width; byte enables are `DATA_WIDTH/8`.
- `Clk` in 1: clock.
- `Reset_n` in 1: reset, synchronous, active-low.
- `IF_Req` in 1: fetch request; held until `IF_Ack` or `Flush`.
- `IF_Addr` in ADDR_WIDTH: fetch address.
- `IF_Rdata` out DATA_WIDTH: fetched instruction; valid while `IF_Ack`=1.
- `IF_Ack` out 1: one-cycle fetch completion pulse.
- `MEM_Req` in 1: load/store request; held until `MEM_Ack`.
- `MEM_We` in 1: 1 = store, 0 = load.
- `MEM_Addr` in ADDR_WIDTH: data address.
- `MEM_Wdata` in DATA_WIDTH: store data.
- `MEM_Be` in DATA_WIDTH/8: store byte enables.
- `MEM_Rdata` out DATA_WIDTH: load data; valid while `MEM_Ack`=1.
- `MEM_Ack` out 1: one-cycle load/store completion pulse.
- `Flush` in 1: branch/jump flush; cancels any pending or in-flight fetch.
- `Bus_Valid` out 1: bus request valid.
- `Bus_We` out 1: bus write.
- `Bus_Addr` out ADDR_WIDTH: bus address.
- `Bus_Wdata` out DATA_WIDTH: bus write data.
- `Bus_Be` out DATA_WIDTH/8: bus byte enables; all ones on reads.
- `Bus_Ready` in 1: transfer complete; read data valid in the same cycle.
- `Bus_Rdata` in DATA_WIDTH: bus read data.
- `Mem_Stall` out 1: `(IF_Req & ~IF_Ack & ~Flush) | (MEM_Req & ~MEM_Ack)`. Combinational.

## Operation
- FSM states:
  - `IDLE`: no bus transaction outstanding.
  - `IF_WAIT`: fetch outstanding on the bus.
  - `MEM_WAIT`: load/store outstanding on the bus.
  - `IF_DROP`: a flushed fetch is still outstanding and its result is discarded.
- `IDLE` → `MEM_WAIT` if `MEM_Req`.
  - MEM has fixed priority, because it belongs to the older instruction.
- `IDLE` → `IF_WAIT` if `IF_Req & ~MEM_Req & ~Flush`.
- On a grant, register `Bus_Valid`=1 with `Bus_We`, `Bus_Addr`, `Bus_Wdata` and `Bus_Be` from the granted requester. Reads drive `Bus_Be`=all ones and `Bus_Wdata`=0.
- Bus outputs stay stable while `Bus_Valid`=1 and `Bus_Ready`=0. A request is never retracted before `Bus_Ready`.
- `*_WAIT`/`IF_DROP` with `Bus_Ready`=1:
  - `Bus_Valid` goes to 0 the next cycle.
  - `Bus_Rdata` is registered into `IF_Rdata` or `MEM_Rdata`.
  - The matching Ack pulses the next cycle. `IF_DROP` issues no Ack.
  - The FSM returns to `IDLE`.
- `IF_WAIT` with `Flush`=1 (and no `Bus_Ready` that cycle) → `IF_DROP`.
- `IF_WAIT` with `Flush` and `Bus_Ready` in the same cycle: no `IF_Ack`; go to `IDLE`.
- `Flush` in `IDLE` suppresses the IF grant that cycle. The MEM grant is unaffected.
- No new grant is made in the Ack cycle. Arbitration resumes in the following `IDLE` cycle.
  - This gives one bubble, so a requester sees its deasserted Req before re-arbitration.
- `MEM_WAIT` ignores `Flush`, because the store/load is older than the branch.
- `Bus_Rdata` is captured only when `Bus_Ready`=1 and the FSM is in a `*_WAIT` state.

## Timing
- Reset (`Reset_n`=0 at a `Clk` edge):
  - State becomes `IDLE`.
  - `Bus_Valid`, `Bus_We`, `IF_Ack` and `MEM_Ack` become 0.
  - `Bus_Addr`, `Bus_Wdata`, `Bus_Be`, `IF_Rdata` and `MEM_Rdata` become 0.
- Reset mid-transaction drops `Bus_Valid` at the next edge. The memory model must tolerate an abandoned request.
- Minimum latency, with `Bus_Ready` already high:
  - Req at cycle 0.
  - `Bus_Valid` at cycle 1.
  - `Bus_Ready` sampled at cycle 1.
  - Ack and data at cycle 2.
  - Earliest next grant at cycle 3.
  - This gives a 3-cycle throughput per transaction.
- Each extra wait cycle on `Bus_Ready` adds one cycle of latency.
- `Mem_Stall` is combinational from the Req inputs and the registered Acks, so it is valid in the same cycle.

## Structure
- Shared package `RV32I_definitions` gains:
  - `arb_state_t` (`IDLE`, `IF_WAIT`, `MEM_WAIT`, `IF_DROP`).
  - `BUS_BE_ALL` constant.
- Single module with one registered FSM, a bus request register group, and response registers. No sub-module is needed.

## Test plan
- Fetch only:
  - Stimulus: `IF_Req`=1, `IF_Addr`=0x100, `Bus_Ready` high from cycle 1, `Bus_Rdata`=0x00500093.
  - Response: `Bus_Valid` at cycle 1 with `Bus_Addr`=0x100 and `Bus_Be`=0xF; `IF_Ack`=1 and `IF_Rdata`=0x00500093 at cycle 2; `Mem_Stall`=1 in cycles 0–1.
- Simultaneous requests:
  - Stimulus: `IF_Req` and `MEM_Req` (store 0xDEADBEEF to 0x2000, `MEM_Be`=0x3) in the same cycle.
  - Response: the bus sees the store first with `Bus_We`=1 and `Bus_Be`=0x3; `MEM_Ack`; one idle cycle; then the fetch is granted.
- Wait states:
  - Stimulus: load from 0x40 with `Bus_Ready` low for 4 cycles.
  - Response: `Bus_Addr` stays stable at 0x40 for 5 cycles; `MEM_Ack` appears one cycle after `Bus_Ready`.
- Flush in flight:
  - Stimulus: `Flush` while in `IF_WAIT`, `Bus_Ready` 2 cycles later.
  - Response: no `IF_Ack` is issued; `Bus_Valid` is held until Ready; the FSM returns to `IDLE`; a new fetch is granted after that.
- Flush coincident with Ready:
  - Response: no `IF_Ack`; `IF_Rdata` is updated but not acked.
- Reset mid-op:
  - Stimulus: `Reset_n`=0 during `MEM_WAIT`.
  - Response: all outputs are 0 at the next edge; the FSM is in `IDLE`.
